// File: rtl/tick_sched_if.sv
// Handshake and status bundle for tick_sched.
// master: drives run and the cfg_valid/cfg_div offer; observes cfg_ready and tick status.
// slave: the scheduler itself; accepts run/config, drives cfg_ready, tick, tick_half, active, cur_div.
interface tick_sched_if #(
  parameter int WIDTH = 8
);
  logic             run;
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;
  logic             tick;
  logic             tick_half;
  logic             active;
  logic [WIDTH-1:0] cur_div;

  modport master (
    output run, cfg_valid, cfg_div,
    input  cfg_ready, tick, tick_half, active, cur_div
  );

  modport slave (
    input  run, cfg_valid, cfg_div,
    output cfg_ready, tick, tick_half, active, cur_div
  );
endinterface

// File: rtl/tick_sched.sv
// Programmable tick scheduler: one-cycle tick every cur_div clocks plus a half-rate square wave.
// Latency: first tick lands div cycles after run is sampled in IDLE; all outputs registered.
// Backpressure: cfg_ready drops while a ratio is pending and returns once it is applied at a period boundary.
//
// Ports:
//   clk_in     - sole clock, rising edge
//   rst_n      - synchronous active-low reset
//   ctrl.run       (in)  level, 1 = count
//   ctrl.cfg_valid (in)  ratio offered on cfg_div
//   ctrl.cfg_div   (in)  requested ratio (values below 2 are stored as 2)
//   ctrl.cfg_ready (out) ratio can be accepted this cycle
//   ctrl.tick      (out) one-cycle pulse per period
//   ctrl.tick_half (out) toggles on every tick
//   ctrl.active    (out) 1 while running
//   ctrl.cur_div   (out) ratio in effect
module tick_sched #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 100
) (
  input  logic       clk_in,
  input  logic       rst_n,
  tick_sched_if.slave ctrl
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cur_div_q;
  logic [WIDTH-1:0] pend_div_q;
  logic             pend_valid_q;
  logic             tick_q;
  logic             tick_half_q;
  logic             active_q;

  logic             cfg_xfer_d;
  logic [WIDTH-1:0] cfg_div_clamped_d;
  logic [WIDTH-1:0] next_div_d;
  logic [WIDTH-1:0] reload_d;
  logic [WIDTH-1:0] cnt_dec_d;

  // Ratio that governs the period about to start: a pending value always
  // takes over at the boundary, so reloads come from it when present.
  // Both candidates are >= 2, so the reload value is always >= 1.
  always_comb begin
    cfg_xfer_d        = ctrl.cfg_valid && !pend_valid_q;
    cfg_div_clamped_d = (ctrl.cfg_div < WIDTH'(2)) ? WIDTH'(2) : ctrl.cfg_div;
    next_div_d        = pend_valid_q ? pend_div_q : cur_div_q;
    reload_d          = next_div_d - WIDTH'(1);
    cnt_dec_d         = cnt_q - WIDTH'(1);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_div_q    <= WIDTH'(DEFAULT_DIV);
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      tick_q       <= 1'b0;
      tick_half_q  <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      // Accepting a ratio and applying a pending one are mutually exclusive
      // (accept needs pend_valid_q=0, apply needs it =1), so the two
      // writes to pend_valid_q below never collide.
      if (cfg_xfer_d) begin
        pend_div_q   <= cfg_div_clamped_d;
        pend_valid_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          tick_q <= 1'b0;
          if (pend_valid_q) begin
            cur_div_q    <= pend_div_q;
            pend_valid_q <= 1'b0;
          end
          if (ctrl.run) begin
            state_q  <= RUN;
            active_q <= 1'b1;
            cnt_q    <= reload_d;
          end
        end

        RUN: begin
          if (!ctrl.run) begin
            // Stop wins over a terminal count: no tick, half-wave frozen.
            state_q  <= IDLE;
            active_q <= 1'b0;
            tick_q   <= 1'b0;
            cnt_q    <= '0;
          end else if (cnt_q == '0) begin
            tick_q      <= 1'b1;
            tick_half_q <= ~tick_half_q;
            cnt_q       <= reload_d;
            if (pend_valid_q) begin
              cur_div_q    <= pend_div_q;
              pend_valid_q <= 1'b0;
            end
          end else begin
            tick_q <= 1'b0;
            cnt_q  <= cnt_dec_d;
          end
        end

        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
          tick_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl.cfg_ready = !pend_valid_q;
  assign ctrl.tick      = tick_q;
  assign ctrl.tick_half = tick_half_q;
  assign ctrl.active    = active_q;
  assign ctrl.cur_div   = cur_div_q;

endmodule

// File: tb/tb_tick_sched.sv
// Randomized plus directed bench for tick_sched against an event-time model.
// The model tracks the absolute edge number of the next tick rather than a counter.
module tb_tick_sched;
  localparam int W   = 8;
  localparam int DEF = 100;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;

  tick_sched_if #(.WIDTH(W)) bus ();

  tick_sched #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .ctrl   (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_vec  = 0;
  int n_err  = 0;
  int edge_n = 0;

  // Reference model state
  bit m_running;
  int m_next;     // edge number at which the next tick is issued
  int m_cur;
  bit m_pv;
  int m_pend;
  bit m_half;
  bit m_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_vec++;
    if (obs !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_edge();
    bit acc;
    int accd;
    edge_n++;
    if (!rst_n) begin
      m_running = 0;
      m_cur     = DEF;
      m_pv      = 0;
      m_half    = 0;
      m_tick    = 0;
    end else begin
      acc    = bus.cfg_valid && !m_pv;
      accd   = (int'(bus.cfg_div) < 2) ? 2 : int'(bus.cfg_div);
      m_tick = 0;
      if (!m_running) begin
        if (m_pv) begin
          m_cur = m_pend;
          m_pv  = 0;
        end
        if (bus.run) begin
          m_running = 1;
          m_next    = edge_n + m_cur;
        end
      end else if (!bus.run) begin
        m_running = 0;
      end else if (edge_n == m_next) begin
        m_tick = 1;
        m_half = !m_half;
        if (m_pv) begin
          m_cur = m_pend;
          m_pv  = 0;
        end
        m_next = edge_n + m_cur;
      end
      if (acc) begin
        m_pend = accd;
        m_pv   = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    chk("tick",      32'(bus.tick),      int'(m_tick));
    chk("tick_half", 32'(bus.tick_half), int'(m_half));
    chk("active",    32'(bus.active),    int'(m_running));
    chk("cur_div",   32'(bus.cur_div),   m_cur);
    chk("cfg_ready", 32'(bus.cfg_ready), int'(!m_pv));
  endtask

  // Hold an offer until it is taken at an edge where cfg_ready was high.
  task automatic offer(input int div);
    bit taken;
    int guard;
    taken = 0;
    guard = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = W'(div);
    while (!taken && guard < 1000) begin
      taken = bus.cfg_ready;
      step();
      guard++;
    end
    bus.cfg_valid = 1'b0;
    chk("offer_accepted", 32'(taken), 1);
  endtask

  initial begin
    int guard;
    bit acc;
    bus.run       = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    rst_n         = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Default ratio: ticks every 100, tick_half period 200
    bus.run = 1'b1;
    repeat (450) step();

    // Ratio 10 offered 40 cycles into a period
    guard = 0;
    while (!(m_running && (m_next - edge_n) == 60) && guard < 300) begin
      step();
      guard++;
    end
    chk("wait_mid_period", 32'(guard < 300), 1);
    offer(10);
    repeat (250) step();

    // Back-to-back offers 5 then 7: 7 is refused, then re-offered and held
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 8'd5;
    step();
    bus.cfg_div   = 8'd7;
    step();
    bus.cfg_valid = 1'b0;
    repeat (3) step();
    offer(7);
    repeat (40) step();

    // Clamp of 0 and 1
    offer(0);
    repeat (30) step();
    offer(1);
    repeat (30) step();

    // Drop run on the terminal-count edge, then re-run
    guard = 0;
    while (!(m_running && m_next == edge_n + 1) && guard < 500) begin
      step();
      guard++;
    end
    chk("wait_terminal", 32'(guard < 500), 1);
    bus.run = 1'b0;
    repeat (6) step();
    bus.run = 1'b1;
    repeat (20) step();

    // Reset mid-period with a pending ratio
    offer(30);
    repeat (70) step();
    offer(60);
    repeat (4) step();
    rst_n   = 1'b0;
    bus.run = 1'b0;
    step();
    step();
    rst_n   = 1'b1;
    step();
    bus.run = 1'b1;
    repeat (210) step();

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 64 == 0) bus.run = ~bus.run;
      if (!bus.cfg_valid && ($urandom % 16 == 0)) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = W'($urandom_range(0, 12));
      end
      rst_n = ($urandom % 500 == 0) ? 1'b0 : 1'b1;
      acc = bus.cfg_valid && bus.cfg_ready && rst_n;
      step();
      if (acc) bus.cfg_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
